// File: rtl/mrsc_encoder_stream_if.sv
// ---------------------------------------------------------------------------
// mrsc_encoder_stream_if
//   Handshake bundle for the streaming MRSC encoder.
//   Input side : in_valid / in_ready / in_data (16-bit data word)
//   Output side: out_valid / out_ready / out_codeword (32-bit codeword)
//   modport master : the environment around the encoder
//                    (it drives the input word and the output-side ready).
//   modport slave  : the encoder itself.
// ---------------------------------------------------------------------------
interface mrsc_encoder_stream_if;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_codeword;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_codeword
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_codeword
  );
endinterface

// File: rtl/mrsc_encoder_stream.sv
// ---------------------------------------------------------------------------
// mrsc_encoder_stream
//   Streaming MRSC (Matrix Region Selection Code) encoder. Each accepted
//   16-bit word is encoded combinationally into the 32-bit codeword layout
//   that mrsc_decoder consumes, then buffered in a 2-entry skid FIFO so that
//   in_ready depends only on registered state.
//
//   Ports
//     clk          single clock, rising edge
//     rst          synchronous, active-high reset
//     flush        synchronous FIFO clear (enc_count is kept)
//     bus          mrsc_encoder_stream_if.slave: in_valid/in_ready/in_data,
//                  out_valid/out_ready/out_codeword
//     enc_count    saturating count of output handshakes (CNT_W bits)
//     inject_mask  XOR mask for one-shot fault injection
//     inject_arm   arms one-shot fault injection
//
//   Build option
//     MRSC_FAULT_INJECT_EN : when defined, a pulse on inject_arm latches
//     inject_mask and the next word written into the FIFO is stored XORed
//     with it. When undefined, inject_mask/inject_arm are ignored.
//
//   Codeword layout
//     [31:16] data, [15:12] {DI1,DI3,DI2,DI4}, [11:8] {P1,P3,P2,P4},
//     [7:0] {XA13,XA24,XB13,XB24,XC13,XC24,XD13,XD24}
// ---------------------------------------------------------------------------
module mrsc_encoder_stream #(
  parameter int CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 flush,
  mrsc_encoder_stream_if.slave bus,
  output logic [CNT_W-1:0]     enc_count,
  input  logic [31:0]          inject_mask,
  input  logic                 inject_arm
);

  localparam logic [1:0] FIFO_EMPTY = 2'd0;
  localparam logic [1:0] FIFO_FULL  = 2'd2;
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  // Nibble n of the word is (A,B,C,D) = ([15:12],[11:8],[7:4],[3:0]);
  // inside a nibble X1 is the msb, so Xi sits at bit (4-i).
  function automatic logic [31:0] mrsc_encode(input logic [15:0] word);
    logic [3:0] a, b, c, d;
    logic       di1, di2, di3, di4;
    logic [3:0] par;
    a   = word[15:12];
    b   = word[11:8];
    c   = word[7:4];
    d   = word[3:0];
    // Diagonals pair adjacent columns of the 4x4 matrix with a swap on
    // every other row, which is what lets the decoder locate a 2-bit error.
    di1 = a[3] ^ b[2] ^ c[3] ^ d[2];
    di2 = a[2] ^ b[3] ^ c[2] ^ d[3];
    di3 = a[1] ^ b[0] ^ c[1] ^ d[0];
    di4 = a[0] ^ b[1] ^ c[0] ^ d[1];
    par = a ^ b ^ c ^ d;  // par[3]=P1 .. par[0]=P4
    mrsc_encode = {word,
                   di1, di3, di2, di4,
                   par[3], par[1], par[2], par[0],
                   a[3] ^ a[1], a[2] ^ a[0],
                   b[3] ^ b[1], b[2] ^ b[0],
                   c[3] ^ c[1], c[2] ^ c[0],
                   d[3] ^ d[1], d[2] ^ d[0]};
  endfunction

  logic [1:0]  count;
  logic        wr_ptr;
  logic        rd_ptr;
  logic [31:0] mem [2];
  logic        push;
  logic        pop;
  logic [31:0] enc_word;
  logic [31:0] stored_word;

  assign bus.in_ready     = (count != FIFO_FULL);
  assign bus.out_valid    = (count != FIFO_EMPTY);
  assign bus.out_codeword = mem[rd_ptr];

  // A push coinciding with flush is dropped; a pop in that cycle is still a
  // real handshake and is counted below.
  assign push     = bus.in_valid && bus.in_ready && !flush;
  assign pop      = bus.out_valid && bus.out_ready;
  assign enc_word = mrsc_encode(bus.in_data);

`ifdef MRSC_FAULT_INJECT_EN
  logic        armed;
  logic [31:0] mask_q;
  logic [31:0] eff_mask;

  // A fresh arm takes effect on a push in the same cycle.
  // NOTE: always_comb assigns a default first so no path leaves eff_mask
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    eff_mask = '0;
    if (inject_arm)
      eff_mask = inject_mask;
    else if (armed)
      eff_mask = mask_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      armed  <= 1'b0;
      mask_q <= '0;
    end else if (flush || push) begin
      armed  <= 1'b0;
    end else if (inject_arm) begin
      armed  <= 1'b1;
      mask_q <= inject_mask;
    end
  end

  assign stored_word = enc_word ^ eff_mask;
`else
  logic unused_inject;
  assign unused_inject = ^{inject_mask, inject_arm};
  assign stored_word   = enc_word;
`endif

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      count  <= FIFO_EMPTY;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      // NOTE: the two storage entries are reset because out_codeword is read
      // straight from them and must be zero out of reset.
      mem[0] <= '0;
      mem[1] <= '0;
    end else if (flush) begin
      count  <= FIFO_EMPTY;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= stored_word;
        wr_ptr      <= ~wr_ptr;
      end
      if (pop)
        rd_ptr <= ~rd_ptr;
      count <= count + {1'b0, push} - {1'b0, pop};
    end
  end

  always_ff @(posedge clk) begin
    if (rst)
      enc_count <= '0;
    else if (pop && (enc_count != CNT_MAX))
      enc_count <= enc_count + CNT_ONE;
  end

endmodule

// File: tb/tb_mrsc_encoder_stream.sv
// ---------------------------------------------------------------------------
// tb_mrsc_encoder_stream
//   Self-checking bench for mrsc_encoder_stream. A queue-based reference
//   model tracks the expected FIFO contents and delivered count; a compare
//   process checks the DUT against it on every falling edge. Directed
//   sequences pin the model with literal codewords; a second instance with
//   CNT_W=2 exercises counter saturation.
// ---------------------------------------------------------------------------
module tb_mrsc_encoder_stream;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic [31:0] inject_mask;
  logic        inject_arm;
  logic [15:0] enc_count;
  logic [1:0]  enc_count2;

  mrsc_encoder_stream_if bus ();
  mrsc_encoder_stream_if bus2 ();

  mrsc_encoder_stream #(.CNT_W(16)) dut (
    .clk         (clk),
    .rst         (rst),
    .flush       (flush),
    .bus         (bus),
    .enc_count   (enc_count),
    .inject_mask (inject_mask),
    .inject_arm  (inject_arm)
  );

  mrsc_encoder_stream #(.CNT_W(2)) dut2 (
    .clk         (clk),
    .rst         (rst),
    .flush       (1'b0),
    .bus         (bus2),
    .enc_count   (enc_count2),
    .inject_mask (32'h0),
    .inject_arm  (1'b0)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference encoder built from the matrix view: nib[k][i] is bit Xi of
  // row k (A..D), X1 being the msb of the row's nibble.
  function automatic logic [31:0] ref_encode(input logic [15:0] d);
    bit nib [4][1:4];
    bit di [1:4];
    bit p [1:4];
    bit x13 [4];
    bit x24 [4];
    for (int k = 0; k < 4; k++)
      for (int i = 1; i <= 4; i++)
        nib[k][i] = d[15 - 4*k - (i-1)];
    di[1] = nib[0][1] ^ nib[1][2] ^ nib[2][1] ^ nib[3][2];
    di[2] = nib[0][2] ^ nib[1][1] ^ nib[2][2] ^ nib[3][1];
    di[3] = nib[0][3] ^ nib[1][4] ^ nib[2][3] ^ nib[3][4];
    di[4] = nib[0][4] ^ nib[1][3] ^ nib[2][4] ^ nib[3][3];
    for (int i = 1; i <= 4; i++)
      p[i] = nib[0][i] ^ nib[1][i] ^ nib[2][i] ^ nib[3][i];
    for (int k = 0; k < 4; k++) begin
      x13[k] = nib[k][1] ^ nib[k][3];
      x24[k] = nib[k][2] ^ nib[k][4];
    end
    return {d, di[1], di[3], di[2], di[4], p[1], p[3], p[2], p[4],
            x13[0], x24[0], x13[1], x24[1], x13[2], x24[2], x13[3], x24[3]};
  endfunction

  // Reference model state
  logic [31:0] mq [$];
  int unsigned m_cnt;
  bit          m_armed;
  logic [31:0] m_mask;
  int          m_sz;
  bit          m_push;
  bit          m_pop;
  logic [31:0] m_eff;

  always @(posedge clk) begin
    if (rst) begin
      mq.delete();
      m_cnt   = 0;
      m_armed = 1'b0;
      m_mask  = '0;
    end else begin
      m_sz   = mq.size();
      m_pop  = (m_sz != 0) && bus.out_ready;
      m_push = bus.in_valid && (m_sz != 2) && !flush;
      m_eff  = '0;
`ifdef MRSC_FAULT_INJECT_EN
      if (inject_arm)
        m_eff = inject_mask;
      else if (m_armed)
        m_eff = m_mask;
`endif
      if (m_pop) begin
        void'(mq.pop_front());
        if (m_cnt != 65535) m_cnt++;
      end
      if (flush)
        mq.delete();
      else if (m_push)
        mq.push_back(ref_encode(bus.in_data) ^ m_eff);
      if (flush || m_push)
        m_armed = 1'b0;
      else if (inject_arm) begin
        m_armed = 1'b1;
        m_mask  = inject_mask;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("in_ready", 32'(bus.in_ready), 32'(mq.size() != 2));
      check("out_valid", 32'(bus.out_valid), 32'(mq.size() != 0));
      if (mq.size() != 0)
        check("out_codeword", bus.out_codeword, mq[0]);
      check("enc_count", 32'(enc_count), m_cnt);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    chk_en = 1'b1;
  endtask

  logic [31:0] exp_inj;

  initial begin
    rst           = 1'b1;
    flush         = 1'b0;
    inject_mask   = '0;
    inject_arm    = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b0;
    bus2.in_valid  = 1'b0;
    bus2.in_data   = '0;
    bus2.out_ready = 1'b1;

    // Reset values, then a single word
    do_reset();
    check("rst_in_ready", 32'(bus.in_ready), 32'd1);
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_codeword", bus.out_codeword, 32'h0);
    check("rst_enc_count", 32'(enc_count), 32'd0);
    bus.in_valid = 1'b1; bus.in_data = 16'h0001; bus.out_ready = 1'b1;
    step();
    bus.in_valid = 1'b0;
    check("single_valid", 32'(bus.out_valid), 32'd1);
    check("single_cw", bus.out_codeword, 32'h0001_4101);
    step();
    check("single_count", 32'(enc_count), 32'd1);

    // Back-to-back stream
    do_reset();
    bus.out_ready = 1'b1;
    bus.in_valid = 1'b1; bus.in_data = 16'h8000;
    step();
    check("stream_cw0", bus.out_codeword, 32'h8000_8880);
    check("stream_rdy0", 32'(bus.in_ready), 32'd1);
    bus.in_data = 16'h0000;
    step();
    check("stream_cw1", bus.out_codeword, 32'h0000_0000);
    check("stream_rdy1", 32'(bus.in_ready), 32'd1);
    bus.in_data = 16'hFFFF;
    step();
    check("stream_cw2", bus.out_codeword, 32'hFFFF_0000);
    check("stream_rdy2", 32'(bus.in_ready), 32'd1);
    bus.in_valid = 1'b0;
    step();
    check("stream_count", 32'(enc_count), 32'd3);

    // Backpressure
    do_reset();
    bus.out_ready = 1'b0;
    bus.in_valid = 1'b1; bus.in_data = 16'h0001;
    step();
    bus.in_data = 16'h8000;
    step();
    bus.in_data = 16'hFFFF;
    check("bp_full", 32'(bus.in_ready), 32'd0);
    check("bp_head", bus.out_codeword, 32'h0001_4101);
    step();
    check("bp_hold_rdy", 32'(bus.in_ready), 32'd0);
    check("bp_hold_cw", bus.out_codeword, 32'h0001_4101);
    bus.out_ready = 1'b1;
    step();
    check("bp_cw1", bus.out_codeword, 32'h8000_8880);
    step();
    bus.in_valid = 1'b0;
    check("bp_cw2", bus.out_codeword, 32'hFFFF_0000);
    step();
    check("bp_empty", 32'(bus.out_valid), 32'd0);
    check("bp_count", 32'(enc_count), 32'd3);

    // Flush with two words buffered and a word offered
    do_reset();
    bus.out_ready = 1'b0;
    bus.in_valid = 1'b1; bus.in_data = 16'h1234;
    step();
    bus.in_data = 16'h5678;
    step();
    bus.in_data = 16'h9ABC; flush = 1'b1;
    step();
    flush = 1'b0; bus.in_valid = 1'b0;
    check("flush_valid", 32'(bus.out_valid), 32'd0);
    check("flush_ready", 32'(bus.in_ready), 32'd1);
    check("flush_count", 32'(enc_count), 32'd0);

    // Saturating counter on the CNT_W=2 instance
    do_reset();
    bus2.in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      bus2.in_data = 16'(i);
      step();
      if (i == 1) check("sat_cnt1", 32'(enc_count2), 32'd1);
      if (i == 2) check("sat_cnt2", 32'(enc_count2), 32'd2);
      if (i == 3) check("sat_cnt3", 32'(enc_count2), 32'd3);
      if (i == 4) check("sat_cnt4", 32'(enc_count2), 32'd3);
    end
    bus2.in_valid = 1'b0;
    step();
    check("sat_cnt5", 32'(enc_count2), 32'd3);

    // One-shot fault injection
    do_reset();
    bus.out_ready = 1'b1;
    inject_mask = 32'h0000_0001; inject_arm = 1'b1;
    step();
    inject_arm = 1'b0;
    bus.in_valid = 1'b1; bus.in_data = 16'h0001;
    step();
`ifdef MRSC_FAULT_INJECT_EN
    exp_inj = 32'h0001_4100;
`else
    exp_inj = 32'h0001_4101;
`endif
    check("inj_first", bus.out_codeword, exp_inj);
    step();
    check("inj_second", bus.out_codeword, 32'h0001_4101);
    bus.in_valid = 1'b0;
    step();

    // Randomized traffic checked by the compare process
    for (int i = 0; i < 600; i++) begin
      bus.in_valid  = ($urandom_range(0, 3) != 0);
      bus.in_data   = 16'($urandom);
      bus.out_ready = ($urandom_range(0, 2) != 0);
      flush         = ($urandom_range(0, 30) == 0);
      inject_arm    = ($urandom_range(0, 15) == 0);
      inject_mask   = $urandom;
      rst           = ($urandom_range(0, 150) == 0);
      step();
    end
    rst = 1'b0; flush = 1'b0; inject_arm = 1'b0;
    bus.in_valid = 1'b0; bus.out_ready = 1'b1;
    step();
    step();
    step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/mrsc_encoder_stream.md
Name: mrsc_encoder_stream

Overview:
- Streaming MRSC (Matrix Region Selection Code, SILVA et al. 2017) encoder.
- Sits directly upstream of mrsc_decoder: accepts 16-bit data words over a valid/ready handshake and emits 32-bit codewords in the layout mrsc_decoder consumes.
- Output side is buffered by a 2-entry skid FIFO, so in_ready depends only on registered state.
- Keeps a saturating count of delivered codewords for scrubbing/monitoring logic.

Parameters:
- CNT_W, 16, width of the delivered-codeword counter enc_count.

Ports:
- clk  input  1  single clock; all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- flush  input  1  synchronous clear of the FIFO; counter is kept
- in_valid  input  1  in_data valid
- in_ready  output  1  block can accept a word this cycle
- in_data  input  16  data word; A=[15:12], B=[11:8], C=[7:4], D=[3:0]; within each nibble, X1=msb … X4=lsb
- out_valid  output  1  out_codeword valid
- out_ready  input  1  downstream accepts this cycle
- out_codeword  output  32  encoded word
- enc_count  output  CNT_W  number of output handshakes, saturating
- inject_mask  input  32  fault-injection XOR mask (see Optional Feature)
- inject_arm  input  1  arms one-shot injection (see Optional Feature)

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high.
- Codeword layout:
  - [31:16] = in_data.
  - [15:12] = {DI1, DI3, DI2, DI4}.
  - [11:8] = {P1, P3, P2, P4}.
  - [7:0] = {XA13, XA24, XB13, XB24, XC13, XC24, XD13, XD24}.
- Diagonal bits:
  - DI1 = A1^B2^C1^D2
  - DI2 = A2^B1^C2^D1
  - DI3 = A3^B4^C3^D4
  - DI4 = A4^B3^C4^D3
- Parity bits: Pn = An^Bn^Cn^Dn.
- Check bits: Xk13 = k1^k3 and Xk24 = k2^k4, for k in {A, B, C, D}.
- Encoding is combinational from in_data. The encoded word is written into the FIFO on accept (in_valid && in_ready).
- FIFO: 2 entries, 2-bit occupancy count, write/read pointers wrap modulo 2.
  - in_ready = (count != 2).
  - out_valid = (count != 0).
  - out_codeword = head entry, driven from registers.
- Latency: a word accepted in cycle N appears with out_valid=1 in cycle N+1 when the FIFO was empty.
- Throughput: 1 word/cycle while out_ready=1.
- Simultaneous push and pop:
  - count unchanged.
  - When count==1, the new entry becomes head in the next cycle.
  - When full, no push can occur because in_ready=0.
- Pop with count==0 is not possible (out_valid=0). Push with count==2 is not possible (in_ready=0).
- out_codeword and out_valid remain stable while out_valid && !out_ready.
- enc_count increments on each out_valid && out_ready and holds at 2^CNT_W-1.
- flush:
  - Next cycle count=0 and pointers=0.
  - Any push in the same cycle is discarded.
  - Any handshake in the same cycle still counts.
  - enc_count is unaffected.
- Reset values:
  - in_ready=1, out_valid=0, out_codeword=0, enc_count=0.
  - Pointers 0, injection disarmed.
- Reset mid-transfer drops all buffered words. No output handshake is counted in the reset cycle.

Optional Feature:
- Macro: MRSC_FAULT_INJECT_EN.
- Defined:
  - A pulse on inject_arm latches inject_mask and sets an armed flag.
  - The next word written into the FIFO is stored as codeword ^ latched mask, then the flag clears.
  - If arm and push coincide, the new mask applies to that same push.
  - flush and rst clear the armed flag.
- Not defined: inject_mask and inject_arm are ignored, no mask register is built, and codewords are stored unmodified.

Test Plan:
- Reset, then in_data=16'h0001, out_ready=1 -> next cycle out_valid=1 and out_codeword=32'h0001_4101; enc_count=1 after handshake.
- Stream 16'h8000, 16'h0000, 16'hFFFF back-to-back with out_ready=1:
  - codewords 32'h8000_8880, 32'h0000_0000, 32'hFFFF_0000 on consecutive cycles.
  - in_ready stays 1; enc_count=3.
- Backpressure: hold out_ready=0 and offer 3 words:
  - first two accepted, then in_ready=0 and the third is stalled.
  - out_codeword holds the first word.
  - Release out_ready -> all three delivered in order.
- Assert flush with 2 words buffered and in_valid=1 -> next cycle out_valid=0, in_ready=1; enc_count unchanged.
- CNT_W=2, 5 handshakes -> enc_count reads 1, 2, 3, 3, 3.
- With MRSC_FAULT_INJECT_EN defined, inject_mask=32'h0000_0001 and arm, then send 16'h0001 twice:
  - first codeword 32'h0001_4100.
  - second codeword 32'h0001_4101.
  - Without the macro, both are 32'h0001_4101.
